horner_poly_pipe: RTL and testbench

//  Fully pipelined fixed-point polynomial evaluator: y = sum_{k=0..DEGREE} a_k*x^k, Horner form, one sample/cycle.

---
 rtl/horner_poly_pipe.sv | 152 +++++++++++++++
 tb/tb_horner_poly_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/horner_poly_pipe.sv
// Pipelined fixed-point Horner polynomial evaluator with valid/ready flow control
// and double-buffered, drain-then-commit runtime coefficients.
module horner_poly_pipe #(
  parameter int WIDTHIN  = 16,
  parameter int FRAC_IN  = 14,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_OUT = 25,
  parameter int DEGREE   = 5,
  parameter logic [(DEGREE+1)*WIDTHIN-1:0] COEF_INIT =
    {16'h0088, 16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [WIDTHIN-1:0]          i_x,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [WIDTHOUT-1:0]         o_y,
  input  logic                        cfg_we,
  input  logic [$clog2(DEGREE+1)-1:0] cfg_addr,
  input  logic [WIDTHIN-1:0]          cfg_data,
  input  logic                        cfg_commit,
  output logic                        cfg_busy
);
  localparam int PW = WIDTHOUT + WIDTHIN;
  localparam int SH = FRAC_OUT - FRAC_IN;

  typedef logic [WIDTHIN-1:0] coef_t;

  function automatic logic [WIDTHOUT-1:0] align(input logic [WIDTHIN-1:0] c);
    logic [PW-1:0] w;
    w = {{WIDTHOUT{1'b0}}, c} << SH;
    return w[WIDTHOUT-1:0];
  endfunction

  function automatic logic [WIDTHOUT-1:0] mul_trunc(input logic [WIDTHOUT-1:0] a,
                                                    input logic [WIDTHIN-1:0]  x);
    logic [PW-1:0] p;
    p = {{WIDTHIN{1'b0}}, a} * {{WIDTHOUT{1'b0}}, x};
    return p[FRAC_IN +: WIDTHOUT];
  endfunction

  coef_t shadow_q [DEGREE+1];
  coef_t shadow_d [DEGREE+1];
  coef_t active_q [DEGREE+1];
  coef_t active_d [DEGREE+1];
  logic  busy_q, busy_d;

  logic                in_v_q;
  logic [WIDTHIN-1:0]  in_x_q;
  logic [WIDTHOUT-1:0] mul_q   [1:DEGREE];
  logic [WIDTHIN-1:0]  mul_x_q [1:DEGREE];
  logic [DEGREE:1]     mul_v_q;
  logic [WIDTHOUT-1:0] add_q   [1:DEGREE];
  logic [WIDTHIN-1:0]  add_x_q [1:DEGREE];
  logic [DEGREE:1]     add_v_q;
  logic                ov_q;
  logic [WIDTHOUT-1:0] y_q;

  logic [WIDTHOUT-1:0] src_acc [1:DEGREE];
  logic [WIDTHIN-1:0]  src_x   [1:DEGREE];
  logic [DEGREE:1]     src_v;

  logic adv, accept, pipe_busy;

  assign adv       = !ov_q || i_ready;
  assign o_ready   = adv && !busy_q;
  assign accept    = i_valid && o_ready;
  assign pipe_busy = in_v_q || (|mul_v_q) || (|add_v_q);

  assign o_valid  = ov_q;
  assign o_y      = y_q;
  assign cfg_busy = busy_q;

  // Multiply stage j consumes the previous add stage; stage 1 starts from the leading coefficient.
  always_comb begin
    src_acc[1] = align(active_q[DEGREE]);
    src_x[1]   = in_x_q;
    src_v      = '0;
    src_v[1]   = in_v_q;
    for (int j = 2; j <= DEGREE; j++) begin
      src_acc[j] = add_q[j-1];
      src_x[j]   = add_x_q[j-1];
      src_v[j]   = add_v_q[j-1];
    end
  end

  // NOTE: every output of a combinational block is given a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    busy_d   = busy_q;
    if (!busy_q) begin
      if (cfg_we && (int'(cfg_addr) <= DEGREE)) shadow_d[cfg_addr] = cfg_data;
      if (cfg_commit) busy_d = 1'b1;
    end else if (!pipe_busy) begin
      // Output reg may still hold a result; it was computed entirely with the old set.
      active_d = shadow_q;
      busy_d   = 1'b0;
    end
  end

  // NOTE: the coefficient banks are reset like ordinary registers because the datapath
  // needs a defined, usable coefficient set immediately after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DEGREE; k++) begin
        shadow_q[k] <= COEF_INIT[k*WIDTHIN +: WIDTHIN];
        active_q[k] <= COEF_INIT[k*WIDTHIN +: WIDTHIN];
      end
      busy_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      busy_q   <= busy_d;
    end
  end

  // NOTE: non-blocking assignments let every stage read the pre-edge value of the stage
  // before it, which is what makes this a pipeline rather than one long combinational chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_v_q  <= 1'b0;
      in_x_q  <= '0;
      mul_v_q <= '0;
      add_v_q <= '0;
      for (int j = 1; j <= DEGREE; j++) begin
        mul_q[j]   <= '0;
        mul_x_q[j] <= '0;
        add_q[j]   <= '0;
        add_x_q[j] <= '0;
      end
      ov_q <= 1'b0;
      y_q  <= '0;
    end else if (adv) begin
      in_v_q <= accept;
      in_x_q <= i_x;
      for (int j = 1; j <= DEGREE; j++) begin
        mul_q[j]   <= mul_trunc(src_acc[j], src_x[j]);
        mul_x_q[j] <= src_x[j];
        mul_v_q[j] <= src_v[j];
        add_q[j]   <= mul_q[j] + align(active_q[DEGREE-j]);
        add_x_q[j] <= mul_x_q[j];
        add_v_q[j] <= mul_v_q[j];
      end
      ov_q <= add_v_q[DEGREE];
      y_q  <= add_q[DEGREE];
    end
  end
endmodule

// File: tb/tb_horner_poly_pipe.sv
// Self-checking bench for horner_poly_pipe: directed vector table, hand-written handshake
// and commit sequences, and a Horner reference model scoreboarding every output.
module tb_horner_poly_pipe;
  localparam int D   = 5;
  localparam int LAT = 2*D + 1;
  localparam logic [95:0] DEF = {16'h0088, 16'h02AA, 16'h0AAA, 16'h2000, 16'h4000, 16'h4000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic        cfg_commit = 1'b0;
  logic [15:0] i_x = '0;
  logic [15:0] cfg_data = '0;
  logic [2:0]  cfg_addr = '0;
  logic        o_ready, o_valid, cfg_busy;
  logic [31:0] o_y;

  always #5 clk = ~clk;

  horner_poly_pipe dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x),
    .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
  );

  typedef struct packed {
    logic [95:0] c;   // {a5,a4,a3,a2,a1,a0}
    logic [15:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t tbl [9];

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [95:0] m_shadow = DEF;
  logic [95:0] m_active = DEF;
  bit          m_busy = 1'b0;
  logic [31:0] exp_q [$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_y = '0;

  bit          acc;
  int          lat, n, sent, g, na, run, out0;
  logic [95:0] c;

  // y = sum a_k x^k evaluated in Horner order with 64-bit integers, wrapped to 32 bits.
  function automatic logic [31:0] poly(input logic [95:0] cf, input logic [15:0] x);
    logic [63:0] a;
    a = (64'(cf[80 +: 16]) << 11) & 64'hFFFF_FFFF;
    for (int k = D-1; k >= 0; k--) begin
      a = ((a * 64'(x)) >> 14) & 64'hFFFF_FFFF;
      a = (a + (64'(cf[k*16 +: 16]) << 11)) & 64'hFFFF_FFFF;
    end
    return a[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(o_valid), 64'd1);
        check("hold_y", 64'(o_y), 64'(prev_y));
      end
      if (o_valid && i_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_out: got %0h expected no result", o_y);
        end else begin
          check("y_model", 64'(o_y), 64'(exp_q.pop_front()));
        end
      end
      if (i_valid && o_ready) exp_q.push_back(poly(m_active, i_x));
      prev_stall = o_valid && !i_ready;
      prev_y     = o_y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_acc(output bit a);
    @(negedge clk);
    a = i_valid && o_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int k, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(k);
    cfg_data = d;
    if (!m_busy && k <= D) m_shadow[k*16 +: 16] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    if (!m_busy) begin
      m_active = m_shadow;
      m_busy   = 1'b1;
    end
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cfg_busy && k < 4*LAT) begin
      tick();
      k++;
    end
    check("busy_clears", 64'(cfg_busy), 64'd0);
    m_busy = 1'b0;
  endtask

  task automatic program_coefs(input logic [95:0] cf);
    for (int k = 0; k <= D; k++) cfg_write(k, cf[k*16 +: 16]);
    commit();
    wait_idle();
  endtask

  task automatic wait_out(output int k);
    k = 0;
    while (!o_valid && k < 4*LAT) begin
      tick();
      k++;
    end
  endtask

  task automatic drain();
    int k = 0;
    i_ready = 1'b1;
    while ((exp_q.size() != 0 || o_valid) && k < 400) begin
      tick();
      k++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_one(input logic [15:0] x, output int l);
    bit a;
    i_valid = 1'b1;
    i_x     = x;
    tick_acc(a);
    i_valid = 1'b0;
    check("accepted", 64'(a), 64'd1);
    wait_out(l);
  endtask

  task automatic test_default_latency();
    int l;
    send_one(16'h0000, l);
    check("lat_2d_plus_1", 64'(l), 64'(LAT));
    check("y_one", 64'(o_y), 64'h0200_0000);
    drain();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{c: DEF,                                           x: 16'h0000, y: 32'h0200_0000};
    tbl[1] = '{c: DEF,                                           x: 16'h4000, y: 32'h056E_E000};
    tbl[2] = '{c: {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0}, x: 16'h2000, y: 32'h0100_0000};
    tbl[3] = '{c: {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0}, x: 16'h4000, y: 32'h0200_0000};
    tbl[4] = '{c: {16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0}, x: 16'h8000, y: 32'h0800_0000};
    tbl[5] = '{c: {16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h4000}, x: 16'h4000, y: 32'h0400_0000};
    tbl[6] = '{c: {16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, x: 16'h8000, y: 32'h4000_0000};
    tbl[7] = '{c: {16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, x: 16'hC000, y: 32'hE600_0000};
    tbl[8] = '{c: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0}, x: 16'h0001, y: 32'h0000_0000};

    tick(); tick(); tick();
    reset = 1'b0;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_y", 64'(o_y), 64'd0);
    check("rst_cfg_busy", 64'(cfg_busy), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd1);

    test_default_latency();

    for (int i = 0; i < 9; i++) begin
      program_coefs(tbl[i].c);
      send_one(tbl[i].x, lat);
      check($sformatf("vec%0d", i), 64'(o_y), 64'(tbl[i].y));
      drain();
    end

    // Back-to-back stream: one result per cycle with a2=1.0 active.
    program_coefs({16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0});
    na = 0;
    for (int i = 0; i < 8; i++) begin
      i_valid = 1'b1;
      i_x     = 16'($urandom);
      tick_acc(acc);
      na += int'(acc);
    end
    i_valid = 1'b0;
    check("b2b_accepts", 64'(na), 64'd8);
    wait_out(n);
    run = 0;
    while (o_valid && run < 20) begin
      tick();
      run++;
    end
    check("b2b_run", 64'(run), 64'd8);
    drain();

    // Random coefficients, 20 samples with 50% downstream backpressure.
    c = {$urandom, $urandom, $urandom};
    program_coefs(c);
    out0 = n_out;
    sent = 0;
    g    = 0;
    i_x  = 16'($urandom);
    while (sent < 20 && g < 400) begin
      i_valid = 1'b1;
      i_ready = 1'($urandom_range(0, 1));
      tick_acc(acc);
      if (acc) begin
        sent++;
        i_x = 16'($urandom);
      end
      g++;
    end
    i_valid = 1'b0;
    check("stream_sent", 64'(sent), 64'd20);
    drain();
    check("stream_count", 64'(n_out - out0), 64'd20);

    // Commit with three samples in flight.
    i_ready = 1'b1;
    for (int k = 0; k <= D; k++) cfg_write(k, 16'($urandom));
    cfg_write(7, 16'hFFFF);
    out0 = n_out;
    na   = 0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_x     = 16'($urandom);
      tick_acc(acc);
      na += int'(acc);
    end
    i_valid = 1'b0;
    check("cm_inflight", 64'(na), 64'd3);
    commit();
    check("cm_busy", 64'(cfg_busy), 64'd1);
    check("cm_o_ready", 64'(o_ready), 64'd0);
    cfg_commit = 1'b1;
    cfg_write(0, ~m_shadow[15:0]);
    cfg_commit = 1'b0;
    i_valid = 1'b1;
    i_x     = 16'($urandom);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 4*LAT) begin
      tick_acc(acc);
      n++;
    end
    i_valid = 1'b0;
    m_busy  = 1'b0;
    check("cm_next_accepted", 64'(acc), 64'd1);
    check("cm_held_off", 64'(n > 3), 64'd1);
    check("cm_busy_cleared", 64'(cfg_busy), 64'd0);
    drain();
    check("cm_count", 64'(n_out - out0), 64'd4);
    commit();
    wait_idle();
    send_one(16'($urandom), lat);
    drain();

    // Reset in the middle of a stream and a pending commit.
    for (int k = 0; k <= D; k++) cfg_write(k, 16'($urandom));
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      i_x     = 16'($urandom);
      tick();
    end
    i_valid = 1'b0;
    commit();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_o_valid", 64'(o_valid), 64'd0);
    check("mid_rst_cfg_busy", 64'(cfg_busy), 64'd0);
    tick();
    reset    = 1'b0;
    m_shadow = DEF;
    m_active = DEF;
    m_busy   = 1'b0;
    test_default_latency();
    send_one(16'h4000, lat);
    check("rst_default_e", 64'(o_y), 64'h056E_E000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
